// File: rtl/exu_result_stage.sv
// rtl/exu_result_stage.sv - registered EX->MEM result stage with 2-entry skid buffer and PC redirect
// Optional misaligned-target trap marking: EXU_MISALIGN_CHECK_EN
module exu_result_stage #(
    parameter int XLEN = 64,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_alu_out,
    input  logic            in_compare_out,
    input  logic            in_word_op,
    input  logic            in_is_branch,
    input  logic            in_is_jal,
    input  logic            in_is_jalr,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [RD_W-1:0] in_rd,
    input  logic            in_rd_wen,
    input  logic            flush_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_result,
    output logic [RD_W-1:0] out_rd,
    output logic            out_rd_wen,
    output logic            out_misalign,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] result;
        logic [RD_W-1:0] rd;
        logic            rd_wen;
        logic            misalign;
    } entry_t;

    state_t          state;
    entry_t          main_q;
    entry_t          skid_q;
    entry_t          new_entry;
    logic            out_valid_q;
    logic            in_ready_q;
    logic            redirect_valid_q;
    logic [XLEN-1:0] redirect_pc_q;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] word_ext;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic            taken;
    logic            new_misalign;
    logic            accept;
    logic            enq;
    logic            emit;
    logic            do_redirect;

    assign pc_plus4 = in_pc + XLEN'(4);
    assign word_ext = {{(XLEN-32){in_alu_out[31]}}, in_alu_out[31:0]};
    assign result   = (in_is_jal | in_is_jalr) ? pc_plus4 :
                      in_word_op               ? word_ext : in_alu_out;
    assign jalr_sum = in_rs1 + in_imm;
    assign target   = in_is_jalr ? (jalr_sum & ~XLEN'(1)) : (in_pc + in_imm);
    assign taken    = in_is_jal | in_is_jalr | (in_is_branch & in_compare_out);

`ifdef EXU_MISALIGN_CHECK_EN
    assign new_misalign = taken & target[1];
`else
    assign new_misalign = 1'b0;
`endif

    assign new_entry.pc       = in_pc;
    assign new_entry.result   = result;
    assign new_entry.rd       = in_rd;
    assign new_entry.rd_wen   = in_rd_wen & ~in_is_branch & (in_rd != '0) & ~new_misalign;
    assign new_entry.misalign = new_misalign;

    // A beat arriving while the redirect pulse is out is on the wrong path.
    assign accept      = in_valid & in_ready_q;
    assign enq         = accept & ~redirect_valid_q & ~flush_i;
    assign emit        = out_valid_q & out_ready;
    assign do_redirect = enq & taken & ~new_misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= EMPTY;
            main_q           <= '0;
            skid_q           <= '0;
            out_valid_q      <= 1'b0;
            in_ready_q       <= 1'b1;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            redirect_valid_q <= do_redirect;
            if (do_redirect) begin
                redirect_pc_q <= target;
            end
            if (flush_i) begin
                state       <= EMPTY;
                out_valid_q <= 1'b0;
                in_ready_q  <= 1'b1;
            end else begin
                case (state)
                    EMPTY: begin
                        if (enq) begin
                            main_q      <= new_entry;
                            out_valid_q <= 1'b1;
                            state       <= ONE;
                        end
                    end
                    ONE: begin
                        if (enq && !emit) begin
                            skid_q     <= new_entry;
                            in_ready_q <= 1'b0;
                            state      <= TWO;
                        end else if (emit && !enq) begin
                            out_valid_q <= 1'b0;
                            state       <= EMPTY;
                        end else if (emit && enq) begin
                            main_q <= new_entry;
                        end
                    end
                    TWO: begin
                        if (emit) begin
                            main_q     <= skid_q;
                            in_ready_q <= 1'b1;
                            state      <= ONE;
                        end
                    end
                    default: begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= EMPTY;
                    end
                endcase
            end
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign out_pc         = main_q.pc;
    assign out_result     = main_q.result;
    assign out_rd         = main_q.rd;
    assign out_rd_wen     = main_q.rd_wen;
    assign out_misalign   = main_q.misalign;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_exu_result_stage.sv
// tb/tb_exu_result_stage.sv - directed vector bench for exu_result_stage
module tb_exu_result_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [63:0] in_alu_out;
    logic        in_compare_out;
    logic        in_word_op;
    logic        in_is_branch;
    logic        in_is_jal;
    logic        in_is_jalr;
    logic [63:0] in_imm;
    logic [63:0] in_rs1;
    logic [4:0]  in_rd;
    logic        in_rd_wen;
    logic        flush_i;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [63:0] out_result;
    logic [4:0]  out_rd;
    logic        out_rd_wen;
    logic        out_misalign;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    exu_result_stage #(.XLEN(64), .RD_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_alu_out(in_alu_out), .in_compare_out(in_compare_out),
        .in_word_op(in_word_op), .in_is_branch(in_is_branch), .in_is_jal(in_is_jal),
        .in_is_jalr(in_is_jalr), .in_imm(in_imm), .in_rs1(in_rs1),
        .in_rd(in_rd), .in_rd_wen(in_rd_wen), .flush_i(flush_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_result(out_result), .out_rd(out_rd),
        .out_rd_wen(out_rd_wen), .out_misalign(out_misalign),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] alu;
        logic [63:0] imm;
        logic [63:0] rs1;
        logic [4:0]  rd;
        logic        wen;
        logic        cmp;
        logic        word;
        logic        br;
        logic        jal;
        logic        jalr;
        logic [63:0] e_res;
        logic        e_wen;
        logic        e_redir;
        logic [63:0] e_rpc;
        logic        e_mis;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_pc = '0; in_alu_out = '0; in_compare_out = 0; in_word_op = 0;
        in_is_branch = 0; in_is_jal = 0; in_is_jalr = 0; in_imm = '0; in_rs1 = '0;
        in_rd = '0; in_rd_wen = 0;
    endtask

    task automatic drive_alu(input logic [63:0] pc, input logic [63:0] alu, input logic [4:0] rd);
        idle_inputs();
        in_valid = 1; in_pc = pc; in_alu_out = alu; in_rd = rd; in_rd_wen = 1;
    endtask

    task automatic drive_vec(input vec_t v);
        in_valid = 1; in_pc = v.pc; in_alu_out = v.alu; in_imm = v.imm; in_rs1 = v.rs1;
        in_rd = v.rd; in_rd_wen = v.wen; in_compare_out = v.cmp; in_word_op = v.word;
        in_is_branch = v.br; in_is_jal = v.jal; in_is_jalr = v.jalr;
    endtask

    initial begin
        logic eff_redir, eff_wen, eff_mis;
        // pc, alu, imm, rs1, rd, wen, cmp, word, br, jal, jalr, e_res, e_wen, e_redir, e_rpc, e_mis
        vecs[0]  = '{64'h1000, 64'h5, 64'h0, 64'h0, 5'd3, 1, 0, 0, 0, 0, 0, 64'h5, 1, 0, 64'h0, 0};
        vecs[1]  = '{64'h1004, 64'h0000_0000_8000_0001, 64'h0, 64'h0, 5'd4, 1, 0, 1, 0, 0, 0,
                     64'hFFFF_FFFF_8000_0001, 1, 0, 64'h0, 0};
        vecs[2]  = '{64'h1008, 64'h1234_5678_7000_0001, 64'h0, 64'h0, 5'd4, 1, 0, 1, 0, 0, 0,
                     64'h0000_0000_7000_0001, 1, 0, 64'h0, 0};
        vecs[3]  = '{64'h100C, 64'h1234_5678_8000_0001, 64'h0, 64'h0, 5'd9, 1, 0, 0, 0, 0, 0,
                     64'h1234_5678_8000_0001, 1, 0, 64'h0, 0};
        vecs[4]  = '{64'h1010, 64'h7, 64'h0, 64'h0, 5'd0, 1, 0, 0, 0, 0, 0, 64'h7, 0, 0, 64'h0, 0};
        vecs[5]  = '{64'h8000_0000, 64'h1, 64'h10, 64'h0, 5'd5, 1, 1, 0, 1, 0, 0,
                     64'h1, 0, 1, 64'h8000_0010, 0};
        vecs[6]  = '{64'h8000_0000, 64'h0, 64'h10, 64'h0, 5'd5, 1, 0, 0, 1, 0, 0,
                     64'h0, 0, 0, 64'h0, 0};
        vecs[7]  = '{64'h2000, 64'h99, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0, 5'd1, 1, 0, 0, 0, 1, 0,
                     64'h2004, 1, 1, 64'h1FF0, 0};
        vecs[8]  = '{64'h3000, 64'h0, 64'h0, 64'h8000_0103, 5'd1, 1, 0, 0, 0, 0, 1,
                     64'h3004, 1, 1, 64'h8000_0102, 1};
        vecs[9]  = '{64'h3100, 64'h0, 64'h21, 64'h8000_0100, 5'd6, 1, 0, 0, 0, 0, 1,
                     64'h3104, 1, 1, 64'h8000_0120, 0};
        vecs[10] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h8, 64'h0, 5'd2, 1, 0, 0, 0, 1, 0,
                     64'h0, 1, 1, 64'h4, 0};
        vecs[11] = '{64'h100, 64'h0, 64'h2, 64'h0, 5'd0, 1, 1, 0, 1, 0, 0,
                     64'h0, 0, 1, 64'h102, 1};
        vecs[12] = '{64'h4000, 64'h8000_0000, 64'h8, 64'h0, 5'd7, 1, 0, 1, 0, 1, 0,
                     64'h4004, 1, 1, 64'h4008, 0};

        idle_inputs();
        flush_i = 0; out_ready = 1; rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_redirect_valid", redirect_valid, 0);
        chk("reset_out_result", out_result, 0);
        rst_n = 1;
        tick();

        for (int i = 0; i < 13; i++) begin
            eff_redir = vecs[i].e_redir;
            eff_wen   = vecs[i].e_wen;
            eff_mis   = 1'b0;
`ifdef EXU_MISALIGN_CHECK_EN
            eff_redir = vecs[i].e_redir & ~vecs[i].e_mis;
            eff_wen   = vecs[i].e_wen & ~vecs[i].e_mis;
            eff_mis   = vecs[i].e_mis;
`endif
            drive_vec(vecs[i]);
            tick();
            idle_inputs();
            chk($sformatf("v%0d_out_valid", i), out_valid, 1);
            chk($sformatf("v%0d_out_pc", i), out_pc, vecs[i].pc);
            chk($sformatf("v%0d_out_result", i), out_result, vecs[i].e_res);
            chk($sformatf("v%0d_out_rd", i), out_rd, vecs[i].rd);
            chk($sformatf("v%0d_out_rd_wen", i), out_rd_wen, eff_wen);
            chk($sformatf("v%0d_out_misalign", i), out_misalign, eff_mis);
            chk($sformatf("v%0d_redirect_valid", i), redirect_valid, eff_redir);
            if (eff_redir)
                chk($sformatf("v%0d_redirect_pc", i), redirect_pc, vecs[i].e_rpc);
            tick();
            chk($sformatf("v%0d_redirect_one_cycle", i), redirect_valid, 0);
            chk($sformatf("v%0d_drained", i), out_valid, 0);
        end

        // Wrong-path drop: beat offered during the redirect pulse never reaches MEM.
        drive_vec(vecs[5]);
        tick();
        chk("wp_redirect_valid", redirect_valid, 1);
        drive_alu(64'h5000, 64'hDEAD, 5'd7);
        tick();
        idle_inputs();
        chk("wp_redirect_cleared", redirect_valid, 0);
        chk("wp_dropped", out_valid, 0);
        tick();
        chk("wp_still_empty", out_valid, 0);

        // Backpressure: three beats, only two fit.
        out_ready = 0;
        drive_alu(64'h6000, 64'hA1, 5'd1);
        tick();
        chk("bp_a_valid", out_valid, 1);
        chk("bp_a_ready", in_ready, 1);
        drive_alu(64'h6004, 64'hB2, 5'd2);
        tick();
        chk("bp_two_ready", in_ready, 0);
        chk("bp_head_a", out_result, 64'hA1);
        drive_alu(64'h6008, 64'hC3, 5'd3);
        tick();
        chk("bp_hold_ready", in_ready, 0);
        chk("bp_hold_a", out_result, 64'hA1);
        chk("bp_hold_pc", out_pc, 64'h6000);
        out_ready = 1;
        tick();
        chk("bp_head_b", out_result, 64'hB2);
        chk("bp_ready_back", in_ready, 1);
        tick();
        idle_inputs();
        chk("bp_head_c", out_result, 64'hC3);
        chk("bp_c_valid", out_valid, 1);
        tick();
        chk("bp_drained", out_valid, 0);

        // Flush in state TWO with a beat offered.
        out_ready = 0;
        drive_alu(64'h7000, 64'h11, 5'd1);
        tick();
        drive_alu(64'h7004, 64'h22, 5'd2);
        tick();
        chk("fl_two", in_ready, 0);
        in_is_jal = 1;
        flush_i = 1;
        tick();
        flush_i = 0;
        idle_inputs();
        chk("fl_out_valid", out_valid, 0);
        chk("fl_in_ready", in_ready, 1);
        tick();
        chk("fl_beat_lost", out_valid, 0);
        chk("fl_no_redirect", redirect_valid, 0);

        // Flush in the same cycle as a taken beat: no redirect.
        drive_vec(vecs[7]);
        flush_i = 1;
        tick();
        flush_i = 0;
        idle_inputs();
        chk("fl_taken_redirect", redirect_valid, 0);
        chk("fl_taken_valid", out_valid, 0);

        // Asynchronous reset mid-operation.
        drive_alu(64'h9000, 64'h33, 5'd3);
        tick();
        drive_alu(64'h9004, 64'h44, 5'd4);
        tick();
        idle_inputs();
        #2;
        rst_n = 0;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_pc", out_pc, 0);
        tick();
        rst_n = 1;
        out_ready = 1;
        tick();
        chk("arst_still_empty", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
